// File: rtl/fu_wb_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fu_wb_tracker_pkg
// Brief    : Writeback unit encodings and destination-tag types.
// Revision : 1.0
// ============================================================================
package fu_wb_tracker_pkg;

    typedef enum logic [2:0] {
        DEFAULT_unit  = 3'd0,
        MUL_unit      = 3'd1,
        FMUL_unit     = 3'd2,
        FADD_SUB_unit = 3'd3,
        R4_unit       = 3'd4,
        FPU_unit      = 3'd5
    } priority_t;

    localparam int WB_TAG_W = 5;
    localparam int NUM_SRC  = 3;

    typedef struct packed {
        logic [WB_TAG_W-1:0] rd;
        logic                fp;
    } wb_tag_t;

    // Integer x0 is hardwired to zero, so it can never be a hazard.
    function automatic logic tag_hit(input wb_tag_t t, input logic [WB_TAG_W-1:0] rd,
                                     input logic fp, input logic used);
        return used && (t.rd == rd) && (t.fp == fp) && !((t.rd == '0) && !t.fp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_wb_tracker_if.sv
`default_nettype none
// ============================================================================
// Interface : fu_wb_tracker_if
// Brief     : Issue, arbiter and hazard signals between a unit and its tracker.
// Revision  : 1.0
// ============================================================================
interface fu_wb_tracker_if;
    import fu_wb_tracker_pkg::*;

    logic                          issue_valid;
    logic [WB_TAG_W-1:0]           issue_rd;
    logic                          issue_fp;
    logic                          issue_ready;
    logic                          stall;
    priority_t                     p_sel;
    logic                          flush;
    logic [NUM_SRC-1:0][WB_TAG_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_fp;
    logic [NUM_SRC-1:0]            src_used;
    logic                          p_signal;
    logic                          p_signal_start;
    logic                          rd_busy;
    logic                          wb_fire;
    logic [WB_TAG_W-1:0]           wb_rd;
    logic                          wb_fp;
    logic [3:0]                    inflight_cnt;
    logic                          protocol_err;

    modport master (
        output issue_valid, issue_rd, issue_fp, stall, p_sel, flush,
               src_addr, src_fp, src_used,
        input  issue_ready, p_signal, p_signal_start, rd_busy, wb_fire,
               wb_rd, wb_fp, inflight_cnt, protocol_err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_fp, stall, p_sel, flush,
               src_addr, src_fp, src_used,
        output issue_ready, p_signal, p_signal_start, rd_busy, wb_fire,
               wb_rd, wb_fp, inflight_cnt, protocol_err
    );

endinterface
`default_nettype wire

// File: rtl/fu_wb_tracker_stage.sv
`default_nettype none
// ============================================================================
// Module   : fu_tag_stage
// Brief    : One {valid, tag} shadow-pipeline register with hold/load/clear.
// Revision : 1.0
// ============================================================================
module fu_tag_stage
    import fu_wb_tracker_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset_n,
    input  wire logic    i_load,
    input  wire logic    i_clear,
    input  wire logic    i_valid,
    input  wire wb_tag_t i_tag,
    output logic         o_valid,
    output wb_tag_t      o_tag
);

    logic    r_valid;
    wb_tag_t r_tag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/fu_wb_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fu_wb_tracker
// Brief    : Shadows a functional unit's pipeline to drive writeback requests
//            and RAW-hazard detection for the writeback arbiter.
// Revision : 1.0
// ============================================================================
module fu_wb_tracker
    import fu_wb_tracker_pkg::*;
#(
    parameter int        LATENCY = 3,
    parameter priority_t UNIT_ID = MUL_unit
)
(
    input  wire logic     clk,
    input  wire logic     reset_n,
    fu_wb_tracker_if.slave bus
);

    localparam logic [3:0] c_lat = 4'(LATENCY);

    logic    w_in_valid [LATENCY];
    wb_tag_t w_in_tag   [LATENCY];
    logic    w_valid    [LATENCY];
    wb_tag_t w_tag      [LATENCY];

    logic       w_last_valid;
    logic       w_fire;
    logic       w_lost;
    logic       w_inc;
    logic       w_busy;
    logic [3:0] r_cnt;
    logic       r_err;

    generate
        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_in_valid[k] = bus.issue_valid;
                assign w_in_tag[k]   = '{rd: bus.issue_rd, fp: bus.issue_fp};
            end else begin : g_body
                assign w_in_valid[k] = w_valid[k-1];
                assign w_in_tag[k]   = w_tag[k-1];
            end

            fu_tag_stage u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .i_load  (~bus.stall),
                .i_clear (bus.flush),
                .i_valid (w_in_valid[k]),
                .i_tag   (w_in_tag[k]),
                .o_valid (w_valid[k]),
                .o_tag   (w_tag[k])
            );
        end
    endgenerate

    assign w_last_valid = w_valid[LATENCY-1];
    assign w_fire       = w_last_valid & (bus.p_sel == UNIT_ID) & ~bus.stall;
    // An unclaimed result is overwritten by the shift; a flush kills it on purpose.
    assign w_lost       = w_last_valid & (bus.p_sel != UNIT_ID) & ~bus.stall & ~bus.flush;
    assign w_inc        = bus.issue_valid & ~bus.stall;

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_valid[k] && tag_hit(w_tag[k], bus.src_addr[i], bus.src_fp[i], bus.src_used[i])) begin
                    w_busy = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
            r_err <= 1'b0;
        end else if (bus.flush) begin
            r_cnt <= 4'd0;
        end else begin
            if (w_inc && !w_fire) begin
                if (r_cnt == c_lat) r_err <= 1'b1;
                else                r_cnt <= r_cnt + 4'd1;
            end else if (w_fire && !w_inc) begin
                if (r_cnt == 4'd0)  r_err <= 1'b1;
                else                r_cnt <= r_cnt - 4'd1;
            end
            if (w_lost) r_err <= 1'b1;
        end
    end

    assign bus.issue_ready    = ~bus.stall;
    assign bus.p_signal_start = w_inc;
    assign bus.p_signal       = w_last_valid;
    assign bus.wb_fire        = w_fire;
    assign bus.wb_rd          = w_tag[LATENCY-1].rd;
    assign bus.wb_fp          = w_tag[LATENCY-1].fp;
    assign bus.rd_busy        = w_busy;
    assign bus.inflight_cnt   = r_cnt;
    assign bus.protocol_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fu_wb_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_wb_tracker
// Brief    : Directed and random checks of fu_wb_tracker against an op-queue model.
// Revision : 1.0
// ============================================================================
module tb_fu_wb_tracker;
    import fu_wb_tracker_pkg::*;

    localparam int        LAT = 3;
    localparam priority_t UID = MUL_unit;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fu_wb_tracker_if bus();

    fu_wb_tracker #(.LATENCY(LAT), .UNIT_ID(UID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Each op remembers the advance count at which it reaches the last stage.
    typedef struct {
        logic [4:0] rd;
        logic       fp;
        int         due;
    } op_t;

    op_t q[$];
    int  m_adv;
    int  m_cnt;
    bit  m_err;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (q.size() > 0) && (q[0].due == m_adv);
    endfunction

    function automatic bit m_fire();
        return m_ready() && (bus.p_sel == UID) && !bus.stall;
    endfunction

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int j = 0; j < q.size(); j++)
            for (int i = 0; i < 3; i++)
                if (bus.src_used[i] && q[j].rd == bus.src_addr[i] && q[j].fp == bus.src_fp[i]
                    && !(q[j].rd == 5'd0 && !q[j].fp))
                    b = 1'b1;
        return b;
    endfunction

    task automatic settle();
        #1;
        check("issue_ready", bus.issue_ready, !bus.stall);
        check("p_signal_start", bus.p_signal_start, bus.issue_valid && !bus.stall);
        check("p_signal", bus.p_signal, m_ready());
        check("wb_fire", bus.wb_fire, m_fire());
        check("rd_busy", bus.rd_busy, m_busy());
        check("inflight_cnt", bus.inflight_cnt, m_cnt);
        check("protocol_err", bus.protocol_err, m_err);
        if (m_ready()) begin
            check("wb_rd", bus.wb_rd, q[0].rd);
            check("wb_fp", bus.wb_fp, q[0].fp);
        end
    endtask

    task automatic tick();
        bit   pv, fire, inc;
        op_t  op;
        pv   = m_ready();
        fire = m_fire();
        inc  = bus.issue_valid && !bus.stall;
        @(posedge clk);
        if (!reset_n) begin
            q.delete(); m_cnt = 0; m_err = 1'b0;
        end else if (bus.flush) begin
            q.delete(); m_cnt = 0;
        end else if (!bus.stall) begin
            if (pv) begin
                if (!fire) m_err = 1'b1;
                void'(q.pop_front());
            end
            m_adv++;
            if (bus.issue_valid) begin
                op.rd = bus.issue_rd; op.fp = bus.issue_fp; op.due = m_adv + LAT - 1;
                q.push_back(op);
            end
            if (inc && !fire) begin
                if (m_cnt == LAT) m_err = 1'b1; else m_cnt++;
            end else if (fire && !inc) begin
                if (m_cnt == 0) m_err = 1'b1; else m_cnt--;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset_n         = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.issue_fp    = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.p_sel       = UID;
        bus.src_addr    = '0;
        bus.src_fp      = '0;
        bus.src_used    = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic fp);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        bus.issue_fp    = fp;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q.delete(); m_adv = 0; m_cnt = 0; m_err = 1'b0;
        idle();

        // reset state
        settle();
        check("rst_p_signal", bus.p_signal, 1'b0);
        check("rst_cnt", bus.inflight_cnt, 4'd0);
        bus.stall = 1'b1;
        #1 check("rst_ready_stall", bus.issue_ready, 1'b0);
        tick();

        // single op, latency LAT
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) issue(5'd5, 1'b0);
            settle();
            if (c == 0) check("t1_start", bus.p_signal_start, 1'b1);
            if (c >= 1 && c <= 3) check("t1_cnt", bus.inflight_cnt, 4'd1);
            if (c == 3) begin
                check("t1_fire", bus.wb_fire, 1'b1);
                check("t1_rd", bus.wb_rd, 5'd5);
            end
            if (c == 4) check("t1_cnt_end", bus.inflight_cnt, 4'd0);
            tick();
        end

        // back-to-back with a two-cycle stall
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 3) issue(5'(c + 1), 1'b0);
            if (c == 3 || c == 4) bus.stall = 1'b1;
            settle();
            if (c == 3 || c == 4) begin
                check("t2_ready", bus.issue_ready, 1'b0);
                check("t2_hold_fire", bus.wb_fire, 1'b0);
                check("t2_hold_rd", bus.wb_rd, 5'd1);
            end
            if (c >= 5 && c <= 7) begin
                check("t2_fire", bus.wb_fire, 1'b1);
                check("t2_rd", bus.wb_rd, 5'(c - 4));
            end
            tick();
        end

        // RAW hazard detection
        idle(); issue(5'd7, 1'b0); settle(); tick();
        idle(); bus.src_addr[1] = 5'd7; bus.src_used[1] = 1'b1;
        settle(); check("t3_busy", bus.rd_busy, 1'b1);
        bus.src_fp[1] = 1'b1;
        settle(); check("t3_fp_mismatch", bus.rd_busy, 1'b0);
        issue(5'd0, 1'b0);
        tick();
        idle(); bus.src_used[0] = 1'b1;
        settle(); check("t3_x0", bus.rd_busy, 1'b0);
        tick();
        repeat (4) begin idle(); settle(); tick(); end

        // flush coincident with a writeback
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) issue(5'd10, 1'b0);
            if (c == 1) issue(5'd11, 1'b1);
            if (c == 3) bus.flush = 1'b1;
            settle();
            if (c == 3) begin
                check("t4_fire", bus.wb_fire, 1'b1);
                check("t4_rd", bus.wb_rd, 5'd10);
            end
            if (c >= 4) begin
                check("t4_cnt", bus.inflight_cnt, 4'd0);
                check("t4_cleared", bus.p_signal, 1'b0);
                check("t4_no_err", bus.protocol_err, 1'b0);
            end
            tick();
        end

        // lost op sets the sticky error
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) issue(5'd12, 1'b0);
            if (c == 3) bus.p_sel = DEFAULT_unit;
            settle();
            if (c >= 4) check("t5_err", bus.protocol_err, 1'b1);
            tick();
        end

        // reset with three ops in flight
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 3) issue(5'(20 + c), 1'b0);
            if (c == 3) begin reset_n = 1'b0; bus.p_sel = DEFAULT_unit; end
            settle();
            if (c >= 4) begin
                bus.src_addr[0] = 5'd21; bus.src_used[0] = 1'b1;
                #1;
                check("t6_busy", bus.rd_busy, 1'b0);
                check("t6_psig", bus.p_signal, 1'b0);
                check("t6_fire", bus.wb_fire, 1'b0);
                check("t6_cnt", bus.inflight_cnt, 4'd0);
                check("t6_err", bus.protocol_err, 1'b0);
            end
            tick();
        end

        // random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            reset_n         = ($urandom_range(0, 99) != 0);
            bus.issue_valid = $urandom_range(0, 1) == 1;
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.issue_fp    = $urandom_range(0, 1) == 1;
            bus.stall       = ($urandom_range(0, 4) == 0);
            bus.flush       = ($urandom_range(0, 29) == 0);
            bus.p_sel       = ($urandom_range(0, 19) == 0) ? priority_t'($urandom_range(0, 5)) : UID;
            for (int i = 0; i < 3; i++) begin
                bus.src_addr[i] = 5'($urandom_range(0, 7));
                bus.src_fp[i]   = $urandom_range(0, 1) == 1;
                bus.src_used[i] = $urandom_range(0, 1) == 1;
            end
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_wb_tracker.md
Name: fu_wb_tracker

Overview:
- Unit-side counterpart of the writeback priority arbiter; one instance sits beside each pipelined functional unit (MUL, FMUL, FADD_SUB, R4, FPU).
- Tracks the destination tags of in-flight operations through a LATENCY-deep shadow pipeline.
- Drives the arbiter inputs for that unit: p_signal (result ready), p_signal_start (issue this cycle) and rd_busy (RAW hazard against the ID-stage sources).
- Consumes the arbiter's per-unit stall and p_sel, freezing the shadow pipeline in lock-step with the unit's datapath.

Parameters:
- LATENCY, 3, unit pipeline depth in cycles, legal range 1..8.
- UNIT_ID, MUL_unit, priority_t value that p_sel carries when this unit wins writeback.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- issue_valid  in  1  ID/EX issues an op to this unit
- issue_rd  in  5  destination register
- issue_fp  in  1  destination is the FP register file
- issue_ready  out  1  issue accepted this cycle; equals ~stall
- stall  in  1  this unit's stall bit from the arbiter
- p_sel  in  priority_t  arbiter grant
- flush  in  1  pipeline kill (branch or trap)
- src_addr  in  3x5  ID-stage rs1/rs2/rs3
- src_fp  in  3  per-source FP-file flag
- src_used  in  3  per-source valid
- p_signal  out  1  last stage valid
- p_signal_start  out  1  issue_valid & issue_ready
- rd_busy  out  1  an ID source matches an in-flight destination
- wb_fire  out  1  last stage valid and granted
- wb_rd  out  5  last-stage tag
- wb_fp  out  1  last-stage FP flag
- inflight_cnt  out  4  ops in flight (0..LATENCY)
- protocol_err  out  1  sticky error flag

Behaviour:
- Shadow pipeline
  - Each stage k in 0..LATENCY-1 holds {valid, rd, fp}; stage LATENCY-1 is the last stage.
  - When stall=0: stage0 loads {issue_valid, issue_rd, issue_fp}; stage k loads stage k-1.
  - When stall=1: all stages hold, and issue is not accepted (issue_ready=0).
  - The last stage is dropped (consumed) on wb_fire. If the last stage is valid, stall=0 and the unit is not granted, the op is lost and protocol_err sets.
- Outputs
  - p_signal = last.valid. Combinational from registered state, so the arbiter sees it in the cycle the result is ready.
  - wb_fire = last.valid & (p_sel==UNIT_ID) & ~stall.
  - wb_rd and wb_fp show the last-stage tag whenever p_signal=1 and are don't-care otherwise.
- Latency: an op accepted at cycle T presents p_signal at cycle T+LATENCY plus the number of stall cycles in between.
- rd_busy
  - Asserts when any valid stage (the last stage included) has rd==src_addr[i], fp==src_fp[i] and src_used[i]=1, for i=0..2.
  - An integer rd of 0 never matches.
  - An op being accepted this cycle is not compared.
- inflight_cnt: +1 on accepted issue and -1 on wb_fire. Both in the same cycle leave it unchanged. Invariant: it equals the number of valid stages; the counter saturates at 0 and LATENCY.
- flush
  - Clears every stage except a last stage that fires this cycle; that writeback completes.
  - inflight_cnt reloads to 0.
  - An issue in the same cycle is dropped.
  - Priority order: reset > flush > normal.
- protocol_err: set on a lost op (defined above) or on an inflight_cnt overflow or underflow attempt. Cleared only by reset.
- Reset (reset_n=0 at a clk edge)
  - All valid bits, inflight_cnt and protocol_err go to 0; tags go to 0.
  - Outputs are then p_signal=0, rd_busy=0, wb_fire=0, and issue_ready follows stall.
  - A reset mid-operation discards all in-flight tags.

Decomposition:
- riscv_types already defines priority_t and the unit encodings. Add WB_TAG_W=5 and a wb_tag_t struct {rd, fp} there.
- One natural sub-module: fu_tag_stage, a single {valid, tag} register with hold/load/clear, instantiated LATENCY times via generate.

Test Plan:
- LATENCY=3, issue rd=5 at cycle 0, no stall, p_sel=UNIT_ID from cycle 3 -> p_signal_start=1 at cycle 0; p_signal=1, wb_fire=1 and wb_rd=5 at cycle 3; inflight_cnt goes 1,1,1,0.
- Issue ops back-to-back at cycles 0-2, stall=1 at cycles 3-4 -> tags frozen and issue_ready=0 for those cycles; wb_fire follows at cycles 5, 6, 7 in order.
- rd 7 in flight, src_addr[1]=7 with src_used[1]=1 -> rd_busy=1. Repeat with src_fp mismatched or rd=0 integer -> rd_busy=0.
- Two stages valid, flush coincident with wb_fire -> the fire completes, the other op is cleared, inflight_cnt=0, no protocol_err.
- Last stage valid, stall=0, p_sel=DEFAULT_unit -> protocol_err=1, and it stays set until reset.
- reset_n low for one cycle with 3 ops in flight -> all outputs return to their reset values the next cycle and no wb_fire occurs.
